// File: rtl/lock_pkg.sv
// lock_pkg -- shared definitions for the PIN entry sequencer.
//
// Holds the FSM state type and its fixed codes, the maximum PIN length,
// the widths of the digit index and tries counter, and nibble helpers.
// PIN digit 0 is the most significant nibble of a 16-bit PIN word.
package lock_pkg;

    localparam int PIN_LEN_MAX = 4;
    localparam int IDX_W       = 2;   // addresses up to PIN_LEN_MAX digits
    localparam int TRIES_W     = 2;   // MAX_TRIES is at most 3

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_ERROR   = 3'd4,
        ST_LOCKOUT = 3'd5,
        ST_PROG    = 3'd6
    } lock_state_t;

    // Digit idx of a PIN word (digit 0 in bits 15:12).
    function automatic logic [3:0] get_nibble(input logic [15:0] pin,
                                              input logic [IDX_W-1:0] idx);
        logic [3:0] nib;
        case (idx)
            2'd0:    nib = pin[15:12];
            2'd1:    nib = pin[11:8];
            2'd2:    nib = pin[7:4];
            default: nib = pin[3:0];
        endcase
        return nib;
    endfunction

    // PIN word with digit idx replaced by d.
    function automatic logic [15:0] set_nibble(input logic [15:0] pin,
                                               input logic [IDX_W-1:0] idx,
                                               input logic [3:0] d);
        logic [15:0] res;
        res = pin;
        case (idx)
            2'd0:    res[15:12] = d;
            2'd1:    res[11:8]  = d;
            2'd2:    res[7:4]   = d;
            default: res[3:0]   = d;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// lock_timer -- lockout duration down-counter.
//
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-high reset (counter cleared)
//   start  in  load the counter with LOCKOUT_CYC
//   done   out high during the last cycle of the lockout window
//
// After start is sampled the counter holds LOCKOUT_CYC, so done rises
// LOCKOUT_CYC-1 cycles later; a state that waits for done therefore
// lasts exactly LOCKOUT_CYC cycles.
module lock_timer #(
    parameter int LOCKOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    localparam int CW = $clog2(LOCKOUT_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CW'(LOCKOUT_CYC);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done = (cnt == CW'(1));

endmodule

// File: rtl/pin_entry_sequencer.sv
// pin_entry_sequencer -- PIN keypad lock sequencer.
//
// Digits arrive on 'digit' and are taken on each rising edge of 'enter'.
// After PIN_LEN digits the entry is checked: a match opens the lock, a
// mismatch shows an error, and MAX_TRIES consecutive mismatches lock the
// keypad out for LOCKOUT_CYC cycles.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   digit[3:0]  in   entered digit, sampled on an accepted enter edge
//   enter       in   digit strobe (level; only its rising edge counts)
//   prog        in   reprogram request in OPEN (LOCK_PIN_PROG_EN only)
//   locked      out  high except in OPEN and PROG
//   unlocked    out  high only in OPEN
//   error       out  high only in ERROR
//   lockout     out  high only in LOCKOUT
//   state[2:0]  out  current state code (debug / checker visibility)
//   tries_left  out  MAX_TRIES minus consecutive failed attempts
//
// Build option: define LOCK_PIN_PROG_EN to add the prog port, the PROG
// state and a writable PIN register. Without it the PIN is DEFAULT_PIN.
//
// Handshake: there is no valid/ready pair; an event is a cycle where
// enter is 1, enter was 0 in the previous cycle, and enter has been seen
// low at least once since reset. Events in CHECK and LOCKOUT are dropped.
module pin_entry_sequencer
    import lock_pkg::*;
#(
    parameter int          PIN_LEN     = 4,
    parameter int          MAX_TRIES   = 3,
    parameter int          LOCKOUT_CYC = 1000,
    parameter logic [15:0] DEFAULT_PIN = 16'h1234
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   digit,
`ifdef LOCK_PIN_PROG_EN
    input  logic         prog,
`endif
    input  logic         enter,
    output logic         locked,
    output logic         unlocked,
    output logic         error,
    output logic         lockout,
    output logic [2:0]   state,
    output logic [TRIES_W-1:0] tries_left
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIN_LEN - 1);

    lock_state_t         state_q, state_next;
    logic                enter_q;
    logic                armed;      // enter seen low since reset
    logic                ev;
    logic [IDX_W-1:0]    idx;
    logic                mismatch;
    logic [TRIES_W-1:0]  fail_cnt;
    logic [TRIES_W:0]    fail_inc;
    logic                timer_start;
    logic                timer_done;

`ifdef LOCK_PIN_PROG_EN
    logic [15:0]         pin;
    logic [15:0]         shadow;
`else
    localparam logic [15:0] pin = DEFAULT_PIN;
`endif

    // A high enter at reset release must not count until it drops.
    assign ev       = enter && !enter_q && armed;
    assign fail_inc = {1'b0, fail_cnt} + 1'b1;

    lock_timer #(
        .LOCKOUT_CYC(LOCKOUT_CYC)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .start (timer_start),
        .done  (timer_done)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next  = state_q;
        timer_start = 1'b0;
        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (ev) begin
                    state_next = (idx == LAST_IDX) ? ST_CHECK : ST_ENTRY;
                end
            end
            ST_CHECK: begin
                if (!mismatch) begin
                    state_next = ST_OPEN;
                end else if (fail_inc == (TRIES_W+1)'(MAX_TRIES)) begin
                    state_next  = ST_LOCKOUT;
                    timer_start = 1'b1;
                end else begin
                    state_next = ST_ERROR;
                end
            end
            ST_OPEN: begin
                if (ev) begin
`ifdef LOCK_PIN_PROG_EN
                    state_next = prog ? ST_PROG : ST_IDLE;
`else
                    state_next = ST_IDLE;
`endif
                end
            end
            ST_ERROR: begin
                if (ev) begin
                    state_next = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (timer_done) begin
                    state_next = ST_IDLE;
                end
            end
`ifdef LOCK_PIN_PROG_EN
            ST_PROG: begin
                if (ev && (idx == LAST_IDX)) begin
                    state_next = ST_OPEN;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: edge detect, digit index, mismatch flag, fail counter, PIN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enter_q  <= 1'b0;
            armed    <= 1'b0;
            idx      <= '0;
            mismatch <= 1'b0;
            fail_cnt <= '0;
`ifdef LOCK_PIN_PROG_EN
            pin      <= DEFAULT_PIN;
            shadow   <= DEFAULT_PIN;
`endif
        end else begin
            enter_q <= enter;
            if (!enter) begin
                armed <= 1'b1;
            end

            // idx is also cleared throughout OPEN so PROG starts at digit 0.
            if (state_next == ST_IDLE || state_q == ST_OPEN) begin
                idx      <= '0;
                mismatch <= 1'b0;
            end else if (ev && (state_q == ST_IDLE || state_q == ST_ENTRY)) begin
                mismatch <= mismatch | (digit != get_nibble(pin, idx));
                idx      <= idx + 1'b1;
            end
`ifdef LOCK_PIN_PROG_EN
            else if (ev && state_q == ST_PROG) begin
                shadow <= set_nibble(shadow, idx, digit);
                idx    <= idx + 1'b1;
                if (idx == LAST_IDX) begin
                    pin <= set_nibble(shadow, idx, digit);
                end
            end
`endif

            if (state_q == ST_CHECK) begin
                fail_cnt <= mismatch ? fail_inc[TRIES_W-1:0] : '0;
            end else if (state_q == ST_LOCKOUT && timer_done) begin
                fail_cnt <= '0;
            end
        end
    end

    // Output decode
    assign state      = state_q;
    assign locked     = !(state_q == ST_OPEN || state_q == ST_PROG);
    assign unlocked   = (state_q == ST_OPEN);
    assign error      = (state_q == ST_ERROR);
    assign lockout    = (state_q == ST_LOCKOUT);
    assign tries_left = TRIES_W'(MAX_TRIES) - fail_cnt;

endmodule
